uart_rx_fifo: RTL and testbench

Parametrised successor to the single-byte UART receiver. It oversamples a serial rx line with a configurable bit period and data width. Each received frame is validated for start glitch and stop framing, then pushed into an internal receive FIFO. The FIFO drains through a valid/ready interface to the DMA/host side, with sticky framing/overrun status and an end-of-frame pulse.

---
 rtl/uart_rx_fifo_if.sv | 11 +
 rtl/uart_rx_fifo.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive stream between the UART receive FIFO head (master) and its consumer (slave).
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a show-ahead receive FIFO with sticky error flags.
// Parity checking (PARITY state, PARITY_ODD, parity_err) is compiled in with UART_RX_PARITY_EN.
//
// state   | meaning
// IDLE    | line idle, waiting for rxs low
// START   | mid start bit, reject glitches
// DATA    | sample data bits LSB first at bit centres
// PARITY  | sample parity bit (UART_RX_PARITY_EN only)
// STOP    | sample stop bit, push / drop / flag
// BREAK   | stop bit was low, wait for line to return high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
`ifdef UART_RX_PARITY_EN
    parameter bit PARITY_ODD   = 1'b0,
`endif
    localparam int PTR_W       = $clog2(FIFO_DEPTH)
) (
    input  logic             clk_r,
    input  logic             rst_r_n,
    input  logic             rx,
    uart_rx_fifo_if.master   rxq,
    output logic [PTR_W:0]   fifo_count,
    output logic             rx_busy,
    output logic             dma_rxend,
    output logic             frame_err,
    output logic             overrun,
`ifdef UART_RX_PARITY_EN
    output logic             parity_err,
`endif
    input  logic             err_clr
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 stop_sample;
    logic                 word_ok;
    logic                 push;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
    logic                 par_mis;
`endif

    always_ff @(posedge clk_r or negedge rst_r_n) begin
        if (!rst_r_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Pointers carry a wrap bit so full and empty are distinguishable without a counter.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop         = !empty && rxq.rx_ready;
    assign stop_sample = (state == ST_STOP) && (cnt == CNT_LAST);
`ifdef UART_RX_PARITY_EN
    assign par_mis     = ((^shift) ^ rxs) != PARITY_ODD;
    assign word_ok     = stop_sample && rxs && !par_bad;
`else
    assign word_ok     = stop_sample && rxs;
`endif
    assign push        = word_ok && (!full || pop);

    assign rxq.rx_valid = !empty;
    assign rxq.rx_data  = mem[rd_ptr[PTR_W-1:0]];
    assign fifo_count   = wr_ptr - rd_ptr;

    always_ff @(posedge clk_r or negedge rst_r_n) begin
        if (!rst_r_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_busy   <= 1'b0;
            dma_rxend <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            dma_rxend <= 1'b0;
            // Clear first so a set event later in this block wins.
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state   <= ST_START;
                        rx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                        if (!rxs) begin
                            state <= ST_DATA;
                        end else begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rxs;
                        idx        <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_bad <= par_mis;
                        if (par_mis) parity_err <= 1'b1;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        dma_rxend <= 1'b1;
                        if (rxs) begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
            if (word_ok && !push) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk_r or negedge rst_r_n) begin
        if (!rst_r_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[PTR_W-1:0]] <= shift;
                wr_ptr                 <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level reference model checked every cycle, plus literal spot checks.
module tb_uart_rx_fifo;
    localparam int C  = 8;
    localparam int D  = 4;
    localparam int H  = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int DB  = 5;
    localparam bit ODD = 1'b1;
    localparam int NB  = DB + 1;
`else
    localparam int DB  = 8;
    localparam int NB  = DB;
`endif
    localparam int CW = $clog2(D) + 1;

    typedef struct {
        longint        edge_at;
        logic [DB-1:0] data;
        bit            stop_ok;
        bit            par_ok;
    } frame_t;

    localparam logic [DB-1:0] V_A5 = (DB == 5) ? DB'(8'h15) : DB'(8'hA5);
    localparam logic [DB-1:0] V_3C = DB'(8'h3C);
    localparam logic [DB-1:0] V_7E = DB'(8'h7E);

    logic          clk_r   = 1'b0;
    logic          rst_r_n = 1'b0;
    logic          rx      = 1'b1;
    logic          err_clr = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          rx_busy;
    logic          dma_rxend;
    logic          frame_err;
    logic          overrun;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    uart_rx_fifo_if #(.DATA_BITS(DB)) rxq ();

    uart_rx_fifo #(
        .CLKS_PER_BIT(C),
        .DATA_BITS(DB),
`ifdef UART_RX_PARITY_EN
        .PARITY_ODD(ODD),
`endif
        .FIFO_DEPTH(D)
    ) dut (
        .clk_r(clk_r),
        .rst_r_n(rst_r_n),
        .rx(rx),
        .rxq(rxq),
        .fifo_count(fifo_count),
        .rx_busy(rx_busy),
        .dma_rxend(dma_rxend),
        .frame_err(frame_err),
        .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .err_clr(err_clr)
    );

    int            checks = 0;
    int            errors = 0;
    longint        cyc = 0;
    longint        pop_at = -1;
    int            ready_mode = 0;
    int            clr_mode = 0;
    int            n_end = 0;
    frame_t        pend[$];
    longint        par_evt[$];
    logic [DB-1:0] q[$];
    bit            m_fe = 1'b0;
    bit            m_ov = 1'b0;
    bit            m_pe = 1'b0;
    bit            m_end = 1'b0;

    initial forever #5 clk_r = ~clk_r;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk_r);
        #1;
    endtask

    // Consumer and error-clear drivers: update 2 time units after each edge.
    initial begin
        rxq.rx_ready = 1'b0;
        forever begin
            @(posedge clk_r);
            #2;
            rxq.rx_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1))
                                             : ((ready_mode == 1) || (cyc + 1 == pop_at));
            err_clr = (clr_mode == 2) ? ($urandom_range(0, 15) == 0) : (clr_mode == 1);
        end
    end

    // Reference model: frames resolve at their computed stop-sample edge.
    initial begin
        frame_t f;
        bit     pop;
        bit     push;
        forever begin
            @(posedge clk_r);
            cyc++;
            if (!rst_r_n) begin
                q.delete();
                pend.delete();
                par_evt.delete();
                m_fe = 0; m_ov = 0; m_pe = 0; m_end = 0;
            end else begin
                pop   = (q.size() > 0) && (rxq.rx_ready === 1'b1);
                push  = 1'b0;
                m_end = 1'b0;
                if (err_clr === 1'b1) begin
                    m_fe = 0; m_ov = 0; m_pe = 0;
                end
                if (par_evt.size() > 0 && par_evt[0] == cyc) begin
                    void'(par_evt.pop_front());
                    m_pe = 1'b1;
                end
                if (pend.size() > 0 && pend[0].edge_at == cyc) begin
                    f     = pend.pop_front();
                    m_end = 1'b1;
                    if (!f.stop_ok) m_fe = 1'b1;
                    else if (f.par_ok) begin
                        if (q.size() < D || pop) push = 1'b1;
                        else m_ov = 1'b1;
                    end
                end
                if (pop) void'(q.pop_front());
                if (push) q.push_back(f.data);
            end
        end
    end

    initial forever begin
        @(negedge clk_r);
        if (rst_r_n) begin
            if (dma_rxend === 1'b1) n_end++;
            chk("rx_valid", rxq.rx_valid, q.size() > 0);
            chk("fifo_count", fifo_count, q.size());
            if (q.size() > 0) chk("rx_data", rxq.rx_data, q[0]);
            chk("dma_rxend", dma_rxend, m_end);
            chk("frame_err", frame_err, m_fe);
            chk("overrun", overrun, m_ov);
`ifdef UART_RX_PARITY_EN
            chk("parity_err", parity_err, m_pe);
`endif
        end
    end

    task automatic send(input logic [DB-1:0] d, input bit stop_ok, input bit par_ok,
                        input int hold_low, input bit pop_at_stop);
        frame_t          f;
        logic [NB+1:0]   bits;
        tick();
        // Start edge is seen 3 edges after the drive (2 sync flops + IDLE detect).
        f.edge_at = cyc + 3 + H + C * (NB + 1);
        f.data    = d;
        f.stop_ok = stop_ok;
        f.par_ok  = par_ok;
        pend.push_back(f);
        if (pop_at_stop) pop_at = f.edge_at;
`ifdef UART_RX_PARITY_EN
        if (!par_ok) par_evt.push_back(f.edge_at - C);
        bits = {stop_ok, (^d) ^ ODD ^ !par_ok, d, 1'b0};
`else
        bits = {stop_ok, d, 1'b0};
`endif
        for (int i = 0; i < NB + 2; i++) begin
            rx = bits[i];
            repeat (C) tick();
        end
        if (!stop_ok) begin
            repeat (hold_low) tick();
            rx = 1'b1;
            repeat (2) tick();
        end
        rx = 1'b1;
    endtask

    task automatic glitch(input int g);
        tick();
        rx = 1'b0;
        repeat (g) tick();
        rx = 1'b1;
        repeat (C) tick();
    endtask

    task automatic pop_expect(input logic [DB-1:0] exp);
        chk("pop_data", rxq.rx_data, exp);
        ready_mode = 1;
        tick();
        ready_mode = 0;
        tick();
    endtask

    task automatic clear_flags();
        clr_mode = 1;
        tick();
        clr_mode = 0;
        tick();
    endtask

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, limit 900000", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int            n0;
        int            kind;
        logic [DB-1:0] d;
        bit            pok;

        repeat (3) tick();
        chk("rst_valid", rxq.rx_valid, 0);
        chk("rst_data", rxq.rx_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_rxend", dma_rxend, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        rst_r_n = 1'b1;
        repeat (2) tick();

        n0 = n_end;
        send(V_A5, 1, 1, 0, 0);
        chk("a5_data", rxq.rx_data, V_A5);
        chk("a5_count", fifo_count, 1);
        chk("a5_rxend_once", n_end - n0, 1);
        pop_expect(V_A5);
        chk("a5_count_popped", fifo_count, 0);

        n0 = n_end;
        glitch(3);
        chk("glitch_rxend", n_end - n0, 0);
        chk("glitch_count", fifo_count, 0);
        chk("glitch_busy", rx_busy, 0);
        chk("glitch_flags", {frame_err, overrun}, 0);

        for (int v = 1; v <= 5; v++) send(DB'(v), 1, 1, 0, 0);
        chk("ovr_count", fifo_count, D);
        chk("ovr_flag", overrun, 1);
        for (int v = 1; v <= 4; v++) pop_expect(DB'(v));
        chk("ovr_drained", fifo_count, 0);
        clear_flags();
        chk("ovr_cleared", overrun, 0);

        n0 = n_end;
        send(V_3C, 0, 1, 30 * C, 0);
        chk("brk_frame_err", frame_err, 1);
        chk("brk_rxend_once", n_end - n0, 1);
        chk("brk_count", fifo_count, 0);
        send(V_7E, 1, 1, 0, 0);
        chk("brk_next_data", rxq.rx_data, V_7E);
        chk("brk_next_count", fifo_count, 1);
        pop_expect(V_7E);
        clear_flags();
        chk("brk_cleared", frame_err, 0);

        for (int v = 8'h11; v <= 8'h14; v++) send(DB'(v), 1, 1, 0, 0);
        chk("sim_full", fifo_count, D);
        send(DB'(8'h15), 1, 1, 0, 1);
        chk("sim_count", fifo_count, D);
        chk("sim_no_overrun", overrun, 0);
        for (int v = 8'h12; v <= 8'h15; v++) pop_expect(DB'(v));
        chk("sim_drained", fifo_count, 0);

`ifdef UART_RX_PARITY_EN
        send(5'h15, 1, 1, 0, 0);
        chk("par_good_data", rxq.rx_data, 5'h15);
        chk("par_good_flag", parity_err, 0);
        pop_expect(5'h15);
        send(5'h15, 1, 0, 0, 0);
        chk("par_bad_flag", parity_err, 1);
        chk("par_bad_count", fifo_count, 0);
        clear_flags();
        chk("par_cleared", parity_err, 0);
`endif

        ready_mode = 2;
        clr_mode   = 2;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            d    = DB'($urandom);
            pok  = 1'b1;
`ifdef UART_RX_PARITY_EN
            pok  = ($urandom_range(0, 5) != 0);
`endif
            if (kind == 0) glitch(int'($urandom_range(1, H - 1)));
            else if (kind == 1) send(d, 0, pok, int'($urandom_range(0, 3 * C)), 0);
            else send(d, 1, pok, 0, 0);
            repeat ($urandom_range(0, C)) tick();
        end
        ready_mode = 1;
        clr_mode   = 0;
        repeat (4 * D) tick();
        ready_mode = 0;
        clear_flags();

        send(V_A5, 1, 1, 0, 0);
        send(V_3C, 0, 1, 0, 0);
`ifdef UART_RX_PARITY_EN
        send(V_7E, 1, 0, 0, 0);
`endif
        tick();
        rx = 1'b0;
        repeat (3 * C) tick();
        chk("mid_busy", rx_busy, 1);
        chk("mid_count", fifo_count, 1);
        rst_r_n = 1'b0;
        rx      = 1'b1;
        repeat (2) tick();
        chk("mrst_count", fifo_count, 0);
        chk("mrst_valid", rxq.rx_valid, 0);
        chk("mrst_data", rxq.rx_data, 0);
        chk("mrst_busy", rx_busy, 0);
        chk("mrst_flags", {frame_err, overrun}, 0);
`ifdef UART_RX_PARITY_EN
        chk("mrst_parity", parity_err, 0);
`endif
        rst_r_n = 1'b1;
        repeat (3) tick();
        send(V_7E, 1, 1, 0, 0);
        chk("post_rst_data", rxq.rx_data, V_7E);
        chk("post_rst_count", fifo_count, 1);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
